// File: rtl/pipelined_addsub_pkg.sv
// Shared configuration helpers for the pipelined adder/subtractor:
// segment width derivation and the legality rule for (N, STAGES).
package pipelined_addsub_pkg;

    localparam int DEFAULT_N      = 8;
    localparam int DEFAULT_STAGES = 2;

    function automatic int seg_width(input int n, input int stages);
        return n / stages;
    endfunction

    // The width must split into equal, non-empty segments.
    function automatic bit cfg_ok(input int n, input int stages);
        return (stages >= 1) && (stages <= n) && ((n % stages) == 0);
    endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for pipelined_addsub. The master side
// supplies operand beats and accepts results; the slave side is the adder.
interface pipelined_addsub_if
    import pipelined_addsub_pkg::*;
#(
    parameter int N = DEFAULT_N
);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         sub;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [N:0]   sum;
    logic         ovf;

    modport master (
        output in_valid, a, b, sub, cin, out_ready,
        input  in_ready, out_valid, sum, ovf
    );

    modport slave (
        input  in_valid, a, b, sub, cin, out_ready,
        output in_ready, out_valid, sum, ovf
    );

endinterface

// File: rtl/addsub_segment.sv
// W-bit ripple-carry chain resolving one pipeline segment of the sum.
module addsub_segment #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic [W:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < W; i++) begin : g_bit
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    assign co = c[W];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell used to build the ripple segments.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined ripple-carry adder/subtractor: one W-bit segment per stage,
// a single global stall, and a valid/ready handshake on both sides.
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int N      = DEFAULT_N,
    parameter int STAGES = DEFAULT_STAGES
) (
    input logic               clk,
    input logic               rst,
    pipelined_addsub_if.slave bus
);

    localparam int W = seg_width(N, STAGES);

    if (!cfg_ok(N, STAGES)) begin : g_cfg_check
        $error("pipelined_addsub: N=%0d must be a multiple of STAGES=%0d with 1 <= STAGES <= N",
               N, STAGES);
    end

    logic advance;

    assign advance      = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * W;
        localparam int HI = LO + W;

        // Operand bits [N-1:LO] still to be summed, plus the carry into bit LO.
        logic [N-1:LO] op_a;
        logic [N-1:LO] op_b;
        logic          c_in;
        logic          v_in;
        logic [W-1:0]  seg_s;
        logic          seg_co;
        logic          v_d, v_q;
        logic          c_d, c_q;
        logic [HI-1:0] s_d, s_q;

        if (k == 0) begin : g_src
            assign op_a = bus.a;
            assign op_b = bus.sub ? ~bus.b : bus.b;
            assign c_in = bus.sub | bus.cin;
            assign v_in = bus.in_valid;
            always_comb s_d = advance ? seg_s : s_q;
        end else begin : g_src
            assign op_a = g_stage[k-1].g_fwd.a_q;
            assign op_b = g_stage[k-1].g_fwd.b_q;
            assign c_in = g_stage[k-1].c_q;
            assign v_in = g_stage[k-1].v_q;
            always_comb s_d = advance ? {seg_s, g_stage[k-1].s_q} : s_q;
        end

        addsub_segment #(.W(W)) u_seg (
            .a  (op_a[HI-1:LO]),
            .b  (op_b[HI-1:LO]),
            .ci (c_in),
            .s  (seg_s),
            .co (seg_co)
        );

        // NOTE: holding is written as "_d = _q" rather than by leaving _d
        // unassigned on a branch; an unassigned path would infer a latch.
        always_comb begin
            v_d = advance ? v_in   : v_q;
            c_d = advance ? seg_co : c_q;
        end

        // NOTE: state updates use non-blocking assignments so every stage
        // samples its predecessor's value from before the clock edge.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else begin
                v_q <= v_d;
                c_q <= c_d;
                s_q <= s_d;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [N-1:HI] a_d, a_q;
            logic [N-1:HI] b_d, b_q;

            always_comb begin
                a_d = advance ? op_a[N-1:HI] : a_q;
                b_d = advance ? op_b[N-1:HI] : b_q;
            end

            // NOTE: data registers are reset as well as valid, so sum and ovf
            // read as zero after reset instead of stale or unknown values.
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end else begin : g_last
            logic ovf_d, ovf_q;

            // Carry into the MSB is recovered from the MSB sum bit: a ^ b ^ s.
            always_comb
                ovf_d = advance ? (op_a[N-1] ^ op_b[N-1] ^ seg_s[W-1] ^ seg_co) : ovf_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else begin
                    ovf_q <= ovf_d;
                end
            end

            assign bus.out_valid = v_q;
            assign bus.sum       = {c_q, s_q};
            assign bus.ovf       = ovf_q;
        end
    end

endmodule
